add_scheduler: RTL

ADD_SCHEDULER -- requirements
Module: add_scheduler

---
 rtl/add_scheduler_pkg.sv | 18 +
 rtl/add_scheduler_rippleadder.sv | 24 ++
 rtl/add_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/add_scheduler_pkg.sv
// Shared definitions for the two-requester nibble-serial add scheduler.
// Holds the FSM encoding, the nibble width and the requester count.
package add_scheduler_pkg;

  localparam int NIB_W = 4;
  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] onehot_req(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/add_scheduler_rippleadder.sv
// Team 4-bit ripple-carry adder; the only adder logic in the scheduler.
// Pure combinational, carry rippling from bit 0 upward.
module rippleadder
  import add_scheduler_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             cout_o
);

  logic [NIB_W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[NIB_W];

endmodule

// File: rtl/add_scheduler.sv
// Round-robin scheduler sharing one 4-bit adder between two requesters;
// each WIDTH-bit add runs serially, one nibble per cycle, LSB nibble first.
//
// state   | meaning
// IDLE    | waiting for a request; grants one requester combinationally
// ADD     | one nibble per cycle through the shared adder
// DONE    | result held on res_* until res_valid & res_ready
module add_scheduler
  import add_scheduler_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             cin0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             id_q;
  logic             ptr_q;
  logic             res_valid_q;

  logic             grant_id;
  logic [NIB_W-1:0] a_nib, b_nib, add_sum;
  logic             add_cout;

  // Lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ptr_q;
    end else if (!req_valid[0]) begin
      grant_id = 1'b1;
    end
  end

  // Gated by rst so a held request cannot show a grant while in reset.
  assign req_ready = (!rst && state_q == ST_IDLE && |req_valid) ?
                     onehot_req(grant_id) : '0;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIB_W +: NIB_W];
        b_nib = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sum_d[i*NIB_W +: NIB_W] = add_sum;
      end
    end
  end

  rippleadder u_adder (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      id_q        <= 1'b0;
      ptr_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            a_q     <= grant_id ? a1 : a0;
            b_q     <= grant_id ? b1 : b0;
            carry_q <= grant_id ? cin1 : cin0;
            id_q    <= grant_id;
            ptr_q   <= ~grant_id;
            idx_q   <= '0;
            state_q <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum_q   <= sum_d;
          carry_q <= add_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_q     <= ST_DONE;
            res_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = sum_q;
  assign res_cout  = carry_q;
  assign res_id    = id_q;

endmodule
